hazard_control_unit: RTL and testbench

- Central hazard controller for the 5-stage 8-bit pipeline (F/D/E/M/W).
- Generates forwarding selects for the E-stage ALU operands, plus stall enables and flush/clear strobes for the F/D, D/E, E/M and M/W pipeline registers.
- Sequences a post-reset pipeline drain and multi-cycle data-memory waits through a small FSM.
- FlushE drives the clr input of the D/E pipeline register.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/forwarding_unit.sv | 26 ++
 rtl/hazard_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE        = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        INIT     = 2'b00,
        RUN      = 2'b01,
        MEM_WAIT = 2'b10
    } hazard_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// E-stage operand bypass select: M result beats W result; x0 is never bypassed.
module forwarding_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] i_rs_e,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_m,
    input  logic                  i_reg_write_w,
    output logic [1:0]            o_forward
);

    always_comb begin
        o_forward = FWD_NONE;
        if (i_rs_e != '0) begin
            if (i_reg_write_m && (i_rs_e == i_rd_m)) begin
                o_forward = FWD_MEM;
            end else if (i_reg_write_w && (i_rs_e == i_rd_w)) begin
                o_forward = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding, stalls, flushes, drain/memory-wait FSM.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
//
// state    | meaning
// INIT     | post-reset drain, bubbles injected for FLUSH_CYCLES cycles
// RUN      | normal issue, load-use / branch / memory-miss detection
// MEM_WAIT | whole pipe frozen until data memory reports ready
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_Rs1D,
    input  logic [REG_ADDR_W-1:0] i_Rs2D,
    input  logic [REG_ADDR_W-1:0] i_Rs1E,
    input  logic [REG_ADDR_W-1:0] i_Rs2E,
    input  logic [REG_ADDR_W-1:0] i_RdE,
    input  logic [REG_ADDR_W-1:0] i_RdM,
    input  logic [REG_ADDR_W-1:0] i_RdW,
    input  logic                  i_RegWriteM,
    input  logic                  i_RegWriteW,
    input  logic [1:0]            i_ResultSrcE,
    input  logic                  i_PCSrcE,
    input  logic                  i_MemAccessM,
    input  logic                  i_mem_ready,
    output logic [1:0]            o_ForwardAE,
    output logic [1:0]            o_ForwardBE,
    output logic                  o_StallF,
    output logic                  o_StallD,
    output logic                  o_StallE,
    output logic                  o_StallM,
    output logic                  o_FlushD,
    output logic                  o_FlushE,
    output logic                  o_FlushW,
`ifdef HAZARD_PERF_EN
    output logic [15:0]           o_stall_count,
    output logic [15:0]           o_flush_count,
`endif
    output logic                  o_mem_timeout
);

    hazard_state_t r_state;
    logic [2:0]    r_drain_cnt;
    logic [7:0]    r_wait_cnt;
    logic          r_mem_timeout;

    logic [1:0]    w_fwd_a;
    logic [1:0]    w_fwd_b;
    logic          w_lw_stall;
    logic          w_mem_miss;

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .i_rs_e        (i_Rs1E),
        .i_rd_m        (i_RdM),
        .i_rd_w        (i_RdW),
        .i_reg_write_m (i_RegWriteM),
        .i_reg_write_w (i_RegWriteW),
        .o_forward     (w_fwd_a)
    );

    forwarding_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .i_rs_e        (i_Rs2E),
        .i_rd_m        (i_RdM),
        .i_rd_w        (i_RdW),
        .i_reg_write_m (i_RegWriteM),
        .i_reg_write_w (i_RegWriteW),
        .o_forward     (w_fwd_b)
    );

    assign w_lw_stall = (i_ResultSrcE == RESULT_SRC_LOAD) && (i_RdE != '0) &&
                        ((i_Rs1D == i_RdE) || (i_Rs2D == i_RdE));
    assign w_mem_miss = i_MemAccessM && !i_mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= INIT;
            r_drain_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_drain_cnt == 3'(FLUSH_CYCLES - 1)) begin
                        r_state     <= RUN;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                RUN: begin
                    if (w_mem_miss) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (i_mem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == 8'(MAX_STALL)) begin
                        // counter parks at the limit; memory may still answer later
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    always_comb begin
        o_ForwardAE = FWD_NONE;
        o_ForwardBE = FWD_NONE;
        o_StallF    = 1'b0;
        o_StallD    = 1'b0;
        o_StallE    = 1'b0;
        o_StallM    = 1'b0;
        o_FlushD    = 1'b0;
        o_FlushE    = 1'b0;
        o_FlushW    = 1'b0;
        // reset is synchronous, so force drain outputs while it is high regardless of state
        if (i_reset || (r_state == INIT)) begin
            o_StallF = 1'b1;
            o_FlushD = 1'b1;
            o_FlushE = 1'b1;
            o_FlushW = 1'b1;
        end else if (r_state == RUN) begin
            o_ForwardAE = w_fwd_a;
            o_ForwardBE = w_fwd_b;
            if (w_mem_miss) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_StallE = 1'b1;
                o_StallM = 1'b1;
                o_FlushW = 1'b1;
            end else if (i_PCSrcE) begin
                o_FlushD = 1'b1;
                o_FlushE = 1'b1;
            end else if (w_lw_stall) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_FlushE = 1'b1;
            end
        end else if (r_state == MEM_WAIT) begin
            o_ForwardAE = w_fwd_a;
            o_ForwardBE = w_fwd_b;
            if (!i_mem_ready) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_StallE = 1'b1;
                o_StallM = 1'b1;
                o_FlushW = 1'b1;
            end
        end
    end

    assign o_mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (o_StallD && ((r_state == RUN) || (r_state == MEM_WAIT)) &&
                (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (o_FlushD && (r_state == RUN) && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; expected values are hand-computed constants.
module tb_hazard_control_unit;

    logic       clk;
    logic       reset;
    logic [2:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MemAccessM, mem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_count, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [6:0] ctrl;
    assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    localparam logic [6:0] C_INIT  = 7'b1000111;
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LW    = 7'b1100010;
    localparam logic [6:0] C_BR    = 7'b0000110;
    localparam logic [6:0] C_MWAIT = 7'b1111001;

    hazard_control_unit #(
        .REG_ADDR_W   (3),
        .FLUSH_CYCLES (2),
        .MAX_STALL    (15)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_Rs1D        (Rs1D),
        .i_Rs2D        (Rs2D),
        .i_Rs1E        (Rs1E),
        .i_Rs2E        (Rs2E),
        .i_RdE         (RdE),
        .i_RdM         (RdM),
        .i_RdW         (RdW),
        .i_RegWriteM   (RegWriteM),
        .i_RegWriteW   (RegWriteW),
        .i_ResultSrcE  (ResultSrcE),
        .i_PCSrcE      (PCSrcE),
        .i_MemAccessM  (MemAccessM),
        .i_mem_ready   (mem_ready),
        .o_ForwardAE   (ForwardAE),
        .o_ForwardBE   (ForwardBE),
        .o_StallF      (StallF),
        .o_StallD      (StallD),
        .o_StallE      (StallE),
        .o_StallM      (StallM),
        .o_FlushD      (FlushD),
        .o_FlushE      (FlushE),
        .o_FlushW      (FlushW),
`ifdef HAZARD_PERF_EN
        .o_stall_count (stall_count),
        .o_flush_count (flush_count),
`endif
        .o_mem_timeout (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0;
        MemAccessM = 0; mem_ready = 1;
    endtask

    // inputs change just after the falling edge; outputs are sampled 1ns later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // reset held 3 cycles, with a forwarding condition present that must be masked
        Rs1E = 3; RdM = 3; RegWriteM = 1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1;
            check("reset_ctrl", 32'(ctrl), 32'(C_INIT));
            check("reset_fwd_a", 32'(ForwardAE), 32'd0);
            check("reset_timeout", 32'(mem_timeout), 32'd0);
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        check("drain1_ctrl", 32'(ctrl), 32'(C_INIT));
        next_cycle(); #1;
        check("drain2_ctrl", 32'(ctrl), 32'(C_INIT));
        next_cycle(); #1;
        check("run_ctrl", 32'(ctrl), 32'(C_NONE));

        // forwarding priority and x0 exclusion
        Rs1E = 3; RdM = 3; RegWriteM = 1; RdW = 3; RegWriteW = 1; #1;
        check("fwd_a_mem", 32'(ForwardAE), 32'h2);
        RegWriteM = 0; #1;
        check("fwd_a_wb", 32'(ForwardAE), 32'h1);
        Rs1E = 0; #1;
        check("fwd_a_x0", 32'(ForwardAE), 32'h0);
        Rs2E = 4; RdM = 4; RegWriteM = 1; RdW = 5; #1;
        check("fwd_b_mem", 32'(ForwardBE), 32'h2);
        Rs2E = 5; #1;
        check("fwd_b_wb", 32'(ForwardBE), 32'h1);
        RegWriteW = 0; #1;
        check("fwd_b_none", 32'(ForwardBE), 32'h0);

        // load-use
        next_cycle(); idle_inputs();
        ResultSrcE = 2'b01; RdE = 2; Rs2D = 2; #1;
        check("lw_ctrl", 32'(ctrl), 32'(C_LW));
        next_cycle(); idle_inputs(); #1;
        check("lw_release", 32'(ctrl), 32'(C_NONE));
        ResultSrcE = 2'b01; RdE = 0; Rs2D = 0; Rs1D = 0; #1;
        check("lw_x0", 32'(ctrl), 32'(C_NONE));
        ResultSrcE = 2'b00; RdE = 2; Rs1D = 2; #1;
        check("lw_not_load", 32'(ctrl), 32'(C_NONE));

        // branch beats load-use
        next_cycle(); idle_inputs();
        PCSrcE = 1; ResultSrcE = 2'b01; RdE = 2; Rs1D = 2; #1;
        check("br_lw_ctrl", 32'(ctrl), 32'(C_BR));
        next_cycle(); idle_inputs();
        PCSrcE = 1; #1;
        check("br_ctrl", 32'(ctrl), 32'(C_BR));

        // memory wait: 4 not-ready cycles with a branch held, then ready
        next_cycle(); idle_inputs();
        MemAccessM = 1; mem_ready = 0; PCSrcE = 1; #1;
        check("mw_enter", 32'(ctrl), 32'(C_MWAIT));
        for (int i = 2; i <= 4; i++) begin
            next_cycle(); #1;
            check("mw_hold", 32'(ctrl), 32'(C_MWAIT));
        end
        Rs1E = 3; RdM = 3; RegWriteM = 1; #1;
        check("mw_fwd_a", 32'(ForwardAE), 32'h2);
        next_cycle(); mem_ready = 1; #1;
        check("mw_ready", 32'(ctrl), 32'(C_NONE));
        next_cycle(); MemAccessM = 0; #1;
        check("mw_branch_after", 32'(ctrl), 32'(C_BR));
        check("mw_no_timeout", 32'(mem_timeout), 32'd0);

        // timeout: 20 cycles not ready; j=1 is the RUN detect cycle
        next_cycle(); idle_inputs();
        MemAccessM = 1; mem_ready = 0;
        for (int j = 1; j <= 20; j++) begin
            #1;
            check("to_ctrl", 32'(ctrl), 32'(C_MWAIT));
            check("to_flag", 32'(mem_timeout), (j >= 18) ? 32'd1 : 32'd0);
            next_cycle();
        end

        // reset mid-wait: drain outputs immediately, flag cleared after the edge
        reset = 1'b1; #1;
        check("rst_mw_ctrl", 32'(ctrl), 32'(C_INIT));
        check("rst_mw_fwd", 32'(ForwardAE), 32'd0);
        next_cycle(); #1;
        check("rst_timeout_clr", 32'(mem_timeout), 32'd0);
        idle_inputs();
        reset = 1'b0; #1;
        check("rst2_drain1", 32'(ctrl), 32'(C_INIT));
        next_cycle(); #1;
        check("rst2_drain2", 32'(ctrl), 32'(C_INIT));
        next_cycle(); #1;
        check("rst2_run", 32'(ctrl), 32'(C_NONE));
        check("rst2_timeout", 32'(mem_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
